output_display_n: RTL and testbench

Parametrised successor to the calculator's 4-digit output stage. It drives DIGITS multiplexed 7-segment digits, a beep LED bank and a buzzer from the controller's cmd/data stream. Signed binary is converted to BCD by a multi-cycle shift-add-3 engine with a busy flag, so wide W is supported without a combinational divider. Adds a floating minus sign, explicit zero display, latest-wins restart and a retriggerable beep timer. Sits between the calculator core and the board pins.

---
 rtl/output_pkg.sv | 28 ++
 rtl/output_bcd_serial.sv | 50 +++++
 rtl/output_display_n.sv | 95 +++++++++
 tb/tb_output_display_n.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// output_pkg: shared command encodings, segment constants and BCD-to-segment decode for the output stage
package output_pkg;
  localparam int OC_N = 2;
  typedef enum logic [OC_N-1:0] {
    OC_NONE = 2'd0,
    OC_NUM  = 2'd1,
    OC_ACK  = 2'd2,
    OC_ERR  = 2'd3
  } oc_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hFD;
  localparam logic [7:0] SEG_E     = 8'h61;
  function automatic logic [7:0] seg_of_bcd(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h03;
      4'd1:    return 8'h9F;
      4'd2:    return 8'h25;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h99;
      4'd5:    return 8'h49;
      4'd6:    return 8'h41;
      4'd7:    return 8'h1F;
      4'd8:    return 8'h01;
      4'd9:    return 8'h09;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/output_bcd_serial.sv
// output_bcd_serial: iterative shift-add-3 binary-to-BCD converter, one magnitude bit per cycle
// Ports: Clock, Reset (async active-low); start/data load a new magnitude (restarts if busy);
// abort cancels; busy while stepping; done marks the final step, when bcd holds the finished result.
module output_bcd_serial #(
  parameter int W      = 16,
  parameter int DIGITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        data,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]        mag;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] adj;
  // bcd is the accumulator after this cycle's step; on the last step it is the result
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = acc[4*k+:4] >= 4'd5 ? acc[4*k+:4] + 4'd3 : acc[4*k+:4];
    bcd = {adj[4*DIGITS-2:0], mag[W-1]};
  end
  assign done = busy && cnt == CW'(1) && !start && !abort;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      mag  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(W);
      mag  <= data;
      acc  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (busy) begin
      acc  <= bcd;
      mag  <= mag << 1;
      cnt  <= cnt - 1'b1;
      busy <= cnt != CW'(1);
    end
  end
endmodule

// File: rtl/output_display_n.sv
// output_display_n: multiplexed DIGITS-digit 7-segment display, beep LEDs and buzzer driven by cmd/data
// Ports: Clock, Reset (async active-low); data/cmd from the controller; busy while converting;
// SD digit enables and SEG {a..g,dp}, both active low; LD all equal to beep; Buzz = ~beep.
import output_pkg::*;
module output_display_n #(
  parameter int DIGITS   = 4,
  parameter int W        = 16,
  parameter int SCAN_DIV = 50000,
  parameter int ACK_LEN  = 250000,
  parameter int ERR_LEN  = 25000000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [W-1:0]      data,
  input  logic [OC_N-1:0]   cmd,
  output logic              busy,
  output logic [DIGITS-1:0] SD,
  output logic [7:0]        SEG,
  output logic [7:0]        LD,
  output logic              Buzz
);
  localparam int IW = $clog2(DIGITS);
  localparam logic signed [W-1:0] MAX_V = W'(10**DIGITS - 1);
  localparam logic signed [W-1:0] MIN_V = W'(-(10**(DIGITS-1) - 1));
  oc_t                 op;
  logic                in_range, start, abort, done;
  logic [W-1:0]        mag;
  logic [4*DIGITS-1:0] cbcd, disp;
  logic                sign, pend_sign, err, beep;
  logic [31:0]         bcnt, scnt;
  logic [IW-1:0]       idx, msd;
  logic [3:0]          nib;
  logic [7:0]          seg_cur;
  assign op       = oc_t'(cmd);
  assign in_range = $signed(data) <= MAX_V && $signed(data) >= MIN_V;
  assign start    = op == OC_NUM && in_range;
  assign abort    = (op == OC_NUM && !in_range) || op == OC_ERR;
  assign mag      = data[W-1] ? -data : data;
  assign LD       = {8{beep}};
  assign Buzz     = ~beep;
  output_bcd_serial #(.W(W), .DIGITS(DIGITS)) u_bcd (
    .Clock(Clock),
    .Reset(Reset),
    .start(start),
    .abort(abort),
    .data (mag),
    .busy (busy),
    .done (done),
    .bcd  (cbcd)
  );
  // msd: leftmost nonzero digit, floored at 0 so a zero value still shows "0"
  always_comb begin
    msd = '0;
    for (int k = 1; k < DIGITS; k++)
      if (disp[4*k+:4] != 4'd0) msd = IW'(k);
    nib = disp[4*idx+:4];
    seg_cur = err ? SEG_E :
              idx <= msd ? seg_of_bcd(nib) :
              (sign && idx == msd + 1'b1) ? SEG_MINUS : SEG_BLANK;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      disp      <= '0;
      sign      <= 1'b0;
      pend_sign <= 1'b0;
      err       <= 1'b0;
      beep      <= 1'b0;
      bcnt      <= '0;
      scnt      <= '0;
      idx       <= '0;
      SD        <= '1;
      SEG       <= SEG_BLANK;
    end else begin
      if (done) begin
        disp <= cbcd;
        sign <= pend_sign;
        err  <= 1'b0;
      end
      if (start) pend_sign <= data[W-1];
      if (op == OC_ACK) err <= 1'b0;
      else if (abort) err <= 1'b1;
      if (op == OC_ACK || abort) begin
        beep <= 1'b1;
        bcnt <= op == OC_ACK ? 32'(ACK_LEN - 1) : 32'(ERR_LEN - 1);
      end else if (beep) begin
        beep <= bcnt != '0;
        bcnt <= bcnt - 32'd1;
      end
      scnt <= scnt == 32'(SCAN_DIV - 1) ? '0 : scnt + 32'd1;
      if (scnt == 32'(SCAN_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      SD  <= ~(DIGITS'(1) << idx);
      SEG <= seg_cur;
    end
  end
endmodule

// File: tb/tb_output_display_n.sv
// tb_output_display_n: directed self-checking bench for output_display_n
module tb_output_display_n;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] data  = '0;
  logic [1:0]  cmd   = 2'd0;
  logic        busy, Buzz;
  logic [3:0]  SD;
  logic [7:0]  SEG, LD;
  int vectors = 0;
  int miscompares = 0;
  output_display_n #(.DIGITS(4), .W(16), .SCAN_DIV(2), .ACK_LEN(5), .ERR_LEN(20)) dut (
    .Clock(Clock), .Reset(Reset), .data(data), .cmd(cmd),
    .busy(busy), .SD(SD), .SEG(SEG), .LD(LD), .Buzz(Buzz)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] c, input logic [15:0] d);
    @(negedge Clock);
    cmd = c;
    data = d;
    @(negedge Clock);
    cmd = 2'd0;
  endtask
  task automatic read_digits(output logic [31:0] v);
    logic [3:0] m;
    v = '0;
    repeat (10) begin
      @(negedge Clock);
      for (int k = 0; k < 4; k++) begin
        m = 4'b1 << k;
        if (SD == ~m) v[8*k+:8] = SEG;
      end
    end
  endtask
  task automatic count_busy(output int n, output bit beeped);
    n = 0;
    beeped = 1'b0;
    while (busy && n < 100) begin
      if (!Buzz) beeped = 1'b1;
      n++;
      @(negedge Clock);
    end
  endtask
  task automatic count_beep(output int n);
    n = 0;
    while (!Buzz && n < 100) begin
      n++;
      @(negedge Clock);
    end
  endtask
  logic [3:0]  sd_exp [8] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
  logic [31:0] v;
  int          n;
  bit          b, saw_old;
  initial begin
    repeat (2) @(negedge Clock);
    chk("rst_busy", busy, 0);
    chk("rst_sd", SD, 4'hF);
    chk("rst_seg", SEG, 8'hFF);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chk($sformatf("scan_sd%0d", i), SD, sd_exp[i]);
      if (i == 0) chk("seg_d0_zero", SEG, 8'h03);
      if (i == 2) chk("seg_d1_blank", SEG, 8'hFF);
    end
    chk("idle_busy", busy, 0);
    chk("idle_buzz", Buzz, 1);
    chk("idle_ld", LD, 0);
    send(2'd1, 16'd1234);
    count_busy(n, b);
    chk("busy_1234", n, 16);
    chk("nobeep_1234", b, 0);
    read_digits(v);
    chk("disp_1234", v, 32'h9F250D99);
    send(2'd1, -16'sd42);
    count_busy(n, b);
    chk("busy_m42", n, 16);
    read_digits(v);
    chk("disp_m42", v, 32'hFFFD9925);
    send(2'd1, -16'sd999);
    count_busy(n, b);
    chk("busy_m999", n, 16);
    read_digits(v);
    chk("disp_m999", v, 32'hFD090909);
    send(2'd1, 16'd10000);
    chk("oor_hi_busy", busy, 0);
    count_beep(n);
    chk("oor_hi_beep", n, 20);
    read_digits(v);
    chk("oor_hi_disp", v, 32'h61616161);
    send(2'd1, 16'd1234);
    @(negedge Clock);
    send(2'd1, -16'sd1000);
    chk("oor_lo_abort", busy, 0);
    count_beep(n);
    chk("oor_lo_beep", n, 20);
    read_digits(v);
    chk("oor_lo_disp", v, 32'h61616161);
    send(2'd2, 16'd0);
    count_beep(n);
    chk("ack_beep", n, 5);
    read_digits(v);
    chk("ack_disp", v, 32'hFD090909);
    send(2'd2, 16'd0);
    cmd = 2'd3;
    @(negedge Clock);
    cmd = 2'd0;
    count_beep(n);
    chk("err_retrig_beep", n, 20);
    read_digits(v);
    chk("err_disp", v, 32'h61616161);
    send(2'd2, 16'd0);
    count_beep(n);
    chk("ack2_beep", n, 5);
    send(2'd1, 16'd1234);
    saw_old = 1'b0;
    repeat (4) begin
      if ((SD == 4'h7 && SEG == 8'h9F) || (SD == 4'hB && SEG == 8'h25) ||
          (SD == 4'hD && SEG == 8'h0D) || (SD == 4'hE && SEG == 8'h99)) saw_old = 1'b1;
      @(negedge Clock);
    end
    cmd = 2'd1;
    data = 16'd7;
    @(negedge Clock);
    cmd = 2'd0;
    n = 0;
    while (busy && n < 100) begin
      if ((SD == 4'h7 && SEG == 8'h9F) || (SD == 4'hB && SEG == 8'h25) ||
          (SD == 4'hD && SEG == 8'h0D) || (SD == 4'hE && SEG == 8'h99)) saw_old = 1'b1;
      n++;
      @(negedge Clock);
    end
    chk("restart_busy", n, 16);
    read_digits(v);
    chk("restart_disp", v, 32'hFFFFFF1F);
    chk("restart_no_old", saw_old, 0);
    send(2'd1, 16'd1234);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sd", SD, 4'hF);
    chk("mid_rst_seg", SEG, 8'hFF);
    @(negedge Clock);
    Reset = 1'b1;
    read_digits(v);
    chk("mid_rst_disp", v, 32'hFFFFFF03);
    chk("mid_rst_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
